// File: rtl/memory_access_if.sv
// Handshake bundle for the memory-access stage: execute input, data-memory port, writeback output.
// The master modport is the stage's view; slave is the surrounding pipeline/memory.
interface memory_access_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            in_is_load;
    logic            in_is_store;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_store_data;
    logic [4:0]      in_rd;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [7:0]      req_wstrb;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;

    logic            wb_valid;
    logic            wb_ready;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_misalign;

    modport master (
        input  in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_store_data, in_rd,
        output in_ready,
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata,
        output wb_valid, wb_we, wb_rd, wb_data, wb_misalign,
        input  wb_ready
    );

    modport slave (
        output in_valid, in_is_load, in_is_store, in_funct3, in_addr, in_store_data, in_rd,
        input  in_ready,
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata,
        input  wb_valid, wb_we, wb_rd, wb_data, wb_misalign,
        output wb_ready
    );
endinterface

// File: rtl/memory_access.sv
// riscv64 memory-access stage: one instruction in flight, issues load/store requests,
// aligns/extends load data and presents one writeback record per instruction.
module memory_access #(
    parameter int XLEN = 64
) (
    input logic            clk,
    input logic            rst_n,
    memory_access_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

    state_t     state;
    logic       ld_q;
    logic [2:0] f3_q;
    logic [2:0] off_q;

    logic            in_ld, in_st, in_mem, in_mis;
    logic [7:0]      in_mask;
    logic [2:0]      in_amsk;
    logic [7:0]      in_strb;
    logic [XLEN-1:0] in_wdata;
    logic [XLEN-1:0] sh_rdata;
    logic [XLEN-1:0] ld_data;

    assign bus.in_ready = (state == IDLE);

    // Both kind bits set resolves to a load.
    always_comb begin
        in_ld  = bus.in_is_load;
        in_st  = bus.in_is_store & ~bus.in_is_load;
        in_mem = in_ld | in_st;
        case (bus.in_funct3[1:0])
            2'd0:    begin in_mask = 8'h01; in_amsk = 3'b000; end
            2'd1:    begin in_mask = 8'h03; in_amsk = 3'b001; end
            2'd2:    begin in_mask = 8'h0F; in_amsk = 3'b011; end
            default: begin in_mask = 8'hFF; in_amsk = 3'b111; end
        endcase
        in_mis   = in_mem && |(bus.in_addr[2:0] & in_amsk);
        in_strb  = in_mask << bus.in_addr[2:0];
        in_wdata = bus.in_store_data << {bus.in_addr[2:0], 3'b000};
    end

    always_comb begin
        sh_rdata = bus.resp_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_data = {{(XLEN-8){sh_rdata[7]}},   sh_rdata[7:0]};
            3'b001:  ld_data = {{(XLEN-16){sh_rdata[15]}}, sh_rdata[15:0]};
            3'b010:  ld_data = {{(XLEN-32){sh_rdata[31]}}, sh_rdata[31:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}},  sh_rdata[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, sh_rdata[15:0]};
            3'b110:  ld_data = {{(XLEN-32){1'b0}}, sh_rdata[31:0]};
            default: ld_data = sh_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            ld_q            <= 1'b0;
            f3_q            <= 3'b000;
            off_q           <= 3'b000;
            bus.req_valid   <= 1'b0;
            bus.req_we      <= 1'b0;
            bus.req_addr    <= '0;
            bus.req_wdata   <= '0;
            bus.req_wstrb   <= '0;
            bus.wb_valid    <= 1'b0;
            bus.wb_we       <= 1'b0;
            bus.wb_rd       <= '0;
            bus.wb_data     <= '0;
            bus.wb_misalign <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    ld_q            <= in_ld;
                    f3_q            <= bus.in_funct3;
                    off_q           <= bus.in_addr[2:0];
                    bus.wb_rd       <= bus.in_rd;
                    bus.wb_misalign <= in_mis;
                    // ALU result and faulting address share the same path.
                    bus.wb_data     <= bus.in_addr;
                    bus.wb_we       <= !in_mem && (bus.in_rd != 5'd0);
                    if (in_mis || !in_mem) begin
                        bus.wb_valid <= 1'b1;
                        state        <= OUT;
                    end else begin
                        bus.req_valid <= 1'b1;
                        bus.req_we    <= in_st;
                        bus.req_addr  <= {bus.in_addr[XLEN-1:3], 3'b000};
                        bus.req_wstrb <= in_st ? in_strb : 8'h00;
                        bus.req_wdata <= in_st ? in_wdata : '0;
                        state         <= REQ;
                    end
                end
                REQ: if (bus.req_ready) begin
                    bus.req_valid <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: if (bus.resp_valid) begin
                    bus.wb_valid <= 1'b1;
                    bus.wb_data  <= ld_q ? ld_data : '0;
                    bus.wb_we    <= ld_q && (bus.wb_rd != 5'd0);
                    state        <= OUT;
                end
                default: if (bus.wb_ready) begin
                    bus.wb_valid    <= 1'b0;
                    bus.wb_misalign <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected requests/writebacks queued at issue,
// compared by a negedge monitor at each handshake.
module tb_memory_access;
    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } req_t;
    typedef struct packed {
        logic [63:0] data;
        logic        we;
        logic [4:0]  rd;
        logic        mis;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    req_t req_q[$];
    wb_t  wb_q[$];
    req_t req_prev, req_cur, req_exp;
    wb_t  wb_prev, wb_cur, wb_exp;
    logic req_pend = 1'b0;
    logic wb_pend = 1'b0;

    memory_access_if #(.XLEN(64)) ifc();
    memory_access #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] strb_mask(input logic [7:0] s);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            req_pend = 1'b0;
            wb_pend  = 1'b0;
        end else begin
            req_cur = '{we: ifc.req_we, addr: ifc.req_addr, strb: ifc.req_wstrb, wdata: ifc.req_wdata};
            if (ifc.req_valid) begin
                if (req_pend) begin
                    chk("req_hold_addr", req_cur.addr, req_prev.addr);
                    chk("req_hold_wdata", req_cur.wdata, req_prev.wdata);
                    chk("req_hold_ctl", {55'd0, req_cur.we, req_cur.strb}, {55'd0, req_prev.we, req_prev.strb});
                end
                if (ifc.req_ready) begin
                    chk("req_expected", 64'(req_q.size() > 0), 64'd1);
                    if (req_q.size() > 0) begin
                        req_exp = req_q.pop_front();
                        chk("req_we", 64'(req_cur.we), 64'(req_exp.we));
                        chk("req_addr", req_cur.addr, req_exp.addr);
                        chk("req_wstrb", 64'(req_cur.strb), 64'(req_exp.strb));
                        chk("req_wdata", req_cur.wdata & strb_mask(req_exp.strb), req_exp.wdata);
                    end
                end
            end
            req_pend = ifc.req_valid && !ifc.req_ready;
            req_prev = req_cur;

            wb_cur = '{data: ifc.wb_data, we: ifc.wb_we, rd: ifc.wb_rd, mis: ifc.wb_misalign};
            if (ifc.wb_valid) begin
                if (wb_pend) begin
                    chk("wb_hold_data", wb_cur.data, wb_prev.data);
                    chk("wb_hold_ctl", {57'd0, wb_cur.we, wb_cur.rd, wb_cur.mis}, {57'd0, wb_prev.we, wb_prev.rd, wb_prev.mis});
                end
                if (ifc.wb_ready) begin
                    chk("wb_expected", 64'(wb_q.size() > 0), 64'd1);
                    if (wb_q.size() > 0) begin
                        wb_exp = wb_q.pop_front();
                        chk("wb_data", wb_cur.data, wb_exp.data);
                        chk("wb_we", 64'(wb_cur.we), 64'(wb_exp.we));
                        chk("wb_rd", 64'(wb_cur.rd), 64'(wb_exp.rd));
                        chk("wb_misalign", 64'(wb_cur.mis), 64'(wb_exp.mis));
                    end
                end
            end
            wb_pend = ifc.wb_valid && !ifc.wb_ready;
            wb_prev = wb_cur;
        end
    end

    // One instruction end to end; expected data/strobe/wdata are hand-derived by the caller.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sd, input logic [4:0] rd,
                          input logic [63:0] rdata, input logic mis,
                          input logic [63:0] exp_data, input logic [7:0] exp_strb,
                          input logic [63:0] exp_wdata,
                          input int rs, input int rdly, input int ws);
        logic mem_op;
        logic is_st;
        mem_op = ld | st;
        is_st  = st & ~ld;
        wb_q.push_back('{data: exp_data, we: (!is_st && rd != 5'd0 && !mis), rd: rd, mis: mis});
        if (mem_op && !mis)
            req_q.push_back('{we: is_st, addr: {addr[63:3], 3'b000}, strb: exp_strb, wdata: exp_wdata});
        chk("in_ready_idle", 64'(ifc.in_ready), 64'd1);
        ifc.in_valid      = 1'b1;
        ifc.in_is_load    = ld;
        ifc.in_is_store   = st;
        ifc.in_funct3     = f3;
        ifc.in_addr       = addr;
        ifc.in_store_data = sd;
        ifc.in_rd         = rd;
        ifc.wb_ready      = 1'b0;
        ifc.req_ready     = 1'b0;
        step();
        ifc.in_valid      = 1'b0;
        ifc.in_addr       = 64'($urandom);
        ifc.in_store_data = {32'($urandom), 32'($urandom)};
        if (!mem_op || mis) begin
            chk("wb_lat", 64'(ifc.wb_valid), 64'd1);
            chk("no_req", 64'(ifc.req_valid), 64'd0);
        end else begin
            chk("req_lat", 64'(ifc.req_valid), 64'd1);
            for (int i = 0; i < rs; i++) begin
                step();
                chk("req_stall_vld", 64'(ifc.req_valid), 64'd1);
                chk("in_ready_busy", 64'(ifc.in_ready), 64'd0);
            end
            ifc.req_ready = 1'b1;
            step();
            ifc.req_ready = 1'b0;
            chk("req_drop", 64'(ifc.req_valid), 64'd0);
            for (int i = 0; i < rdly; i++) begin
                step();
                chk("wb_early", 64'(ifc.wb_valid), 64'd0);
            end
            ifc.resp_valid = 1'b1;
            ifc.resp_rdata = rdata;
            step();
            ifc.resp_valid = 1'b0;
            ifc.resp_rdata = {32'($urandom), 32'($urandom)};
            chk("wb_lat", 64'(ifc.wb_valid), 64'd1);
        end
        for (int i = 0; i < ws; i++) begin
            step();
            chk("wb_stall_vld", 64'(ifc.wb_valid), 64'd1);
            chk("in_ready_busy", 64'(ifc.in_ready), 64'd0);
        end
        ifc.wb_ready = 1'b1;
        step();
        ifc.wb_ready = 1'b0;
        chk("wb_drop", 64'(ifc.wb_valid), 64'd0);
        chk("in_ready_after", 64'(ifc.in_ready), 64'd1);
        chk("sb_drained", 64'(wb_q.size() + req_q.size()), 64'd0);
    endtask

    localparam logic [63:0] RD_HI = 64'h8765_4321_0000_0000;

    initial begin
        ifc.in_valid = 1'b0; ifc.in_is_load = 1'b0; ifc.in_is_store = 1'b0;
        ifc.in_funct3 = 3'b000; ifc.in_addr = '0; ifc.in_store_data = '0; ifc.in_rd = '0;
        ifc.req_ready = 1'b0; ifc.resp_valid = 1'b0; ifc.resp_rdata = '0; ifc.wb_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("rst_req_valid", 64'(ifc.req_valid), 64'd0);
        chk("rst_wb_valid", 64'(ifc.wb_valid), 64'd0);
        chk("rst_wb_data", ifc.wb_data, 64'd0);
        rst_n = 1'b1;
        step();

        //     ld    st    f3      addr       sd                      rd  rdata                   mis   exp_data                 strb   wdata
        run_op(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5, 64'h0, 1'b0, 64'h1234, 8'h00, 64'h0, 0, 0, 0);
        run_op(1'b0, 1'b0, 3'b000, 64'h77, 64'h0, 5'd0, 64'h0, 1'b0, 64'h77, 8'h00, 64'h0, 0, 0, 1);
        run_op(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 5'd7, 64'h8000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'h0, 0, 0, 0);
        run_op(1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 5'd7, 64'h8000_0000, 1'b0, 64'h80, 8'h00, 64'h0, 0, 0, 0);
        run_op(1'b0, 1'b1, 3'b001, 64'h2006, 64'hFFFF_FFFF_FFFF_ABCD, 5'd9, 64'h0, 1'b0, 64'h0, 8'hC0, 64'hABCD_0000_0000_0000, 0, 0, 0);
        run_op(1'b1, 1'b0, 3'b010, 64'h3002, 64'h0, 5'd3, 64'h0, 1'b1, 64'h3002, 8'h00, 64'h0, 0, 0, 0);
        run_op(1'b1, 1'b0, 3'b011, 64'h4000, 64'h0, 5'd10, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, 3, 2, 2);
        run_op(1'b1, 1'b0, 3'b001, 64'h16, 64'h0, 5'd11, RD_HI, 1'b0, 64'hFFFF_FFFF_FFFF_8765, 8'h00, 64'h0, 0, 1, 0);
        run_op(1'b1, 1'b0, 3'b101, 64'h16, 64'h0, 5'd11, RD_HI, 1'b0, 64'h8765, 8'h00, 64'h0, 1, 0, 0);
        run_op(1'b1, 1'b0, 3'b010, 64'h4, 64'h0, 5'd12, RD_HI, 1'b0, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0, 0, 0, 0);
        run_op(1'b1, 1'b0, 3'b110, 64'h4, 64'h0, 5'd12, RD_HI, 1'b0, 64'h8765_4321, 8'h00, 64'h0, 0, 0, 1);
        run_op(1'b0, 1'b1, 3'b000, 64'h5001, 64'h1234_5655, 5'd1, 64'h0, 1'b0, 64'h0, 8'h02, 64'h5500, 0, 0, 0);
        run_op(1'b0, 1'b1, 3'b011, 64'h5008, 64'h1122_3344_5566_7788, 5'd2, 64'h0, 1'b0, 64'h0, 8'hFF, 64'h1122_3344_5566_7788, 2, 0, 0);
        run_op(1'b1, 1'b1, 3'b100, 64'h1003, 64'h0, 5'd4, 64'h8000_0000, 1'b0, 64'h80, 8'h00, 64'h0, 0, 0, 0);
        run_op(1'b0, 1'b1, 3'b010, 64'h5006, 64'h0, 5'd6, 64'h0, 1'b1, 64'h5006, 8'h00, 64'h0, 0, 0, 1);
        run_op(1'b1, 1'b0, 3'b001, 64'h16, 64'h0, 5'd0, RD_HI, 1'b0, 64'hFFFF_FFFF_FFFF_8765, 8'h00, 64'h0, 0, 0, 0);

        // Reset while waiting for a load response.
        ifc.in_valid = 1'b1; ifc.in_is_load = 1'b1; ifc.in_is_store = 1'b0;
        ifc.in_funct3 = 3'b011; ifc.in_addr = 64'h6000; ifc.in_rd = 5'd8;
        step();
        ifc.in_valid = 1'b0;
        ifc.req_ready = 1'b1;
        req_q.push_back('{we: 1'b0, addr: 64'h6000, strb: 8'h00, wdata: 64'h0});
        step();
        ifc.req_ready = 1'b0;
        chk("rst_mid_in_ready_busy", 64'(ifc.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("rst_mid_req_valid", 64'(ifc.req_valid), 64'd0);
        chk("rst_mid_req_addr", ifc.req_addr, 64'd0);
        chk("rst_mid_wb_valid", 64'(ifc.wb_valid), 64'd0);
        chk("rst_mid_wb_rd", 64'(ifc.wb_rd), 64'd0);
        chk("rst_mid_sb", 64'(req_q.size()), 64'd0);
        step();
        rst_n = 1'b1;
        ifc.resp_valid = 1'b1;
        ifc.resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        ifc.resp_valid = 1'b0;
        step();
        chk("stale_resp_wb", 64'(ifc.wb_valid), 64'd0);
        chk("stale_resp_in_ready", 64'(ifc.in_ready), 64'd1);
        run_op(1'b0, 1'b0, 3'b000, 64'hCAFE, 64'h0, 5'd13, 64'h0, 1'b0, 64'hCAFE, 8'h00, 64'h0, 0, 0, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
